// File: rtl/encoder_emulator.sv
// ============================================================================
// encoder_emulator : quadrature A/B generator, signed step count at a set rate
// Revision: 1.0
// ============================================================================
`default_nettype none

module encoder_emulator #(
  parameter int STEP_WIDTH = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int POS_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic signed [STEP_WIDTH-1:0] steps,
  input  logic        [DIV_WIDTH-1:0]  period,
  output logic                        a,
  output logic                        b,
  output logic                        busy,
  output logic                        done,
  output logic signed [POS_WIDTH-1:0]  pos
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                       state_q, state_d;
  logic                         dir_q, dir_d;
  logic [STEP_WIDTH-1:0]        rem_q, rem_d;
  logic [DIV_WIDTH-1:0]         per_q, per_d;
  logic [DIV_WIDTH-1:0]         cnt_q, cnt_d;
  logic [1:0]                   phase_q, phase_d;
  logic signed [POS_WIDTH-1:0]  pos_q, pos_d;
  logic                         done_q, done_d;
  logic                         a_q, a_d;
  logic                         b_q, b_d;

  logic [STEP_WIDTH-1:0]        mag_w;
  logic [DIV_WIDTH-1:0]         per_w;

  // The most negative request has no signed magnitude but fits unsigned.
  assign mag_w = steps[STEP_WIDTH-1] ? $unsigned(-steps) : $unsigned(steps);
  assign per_w = (period == '0) ? DIV_WIDTH'(1) : period;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      rem_q   <= '0;
      per_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 2'd0;
      pos_q   <= '0;
      done_q  <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
      per_q   <= per_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      pos_q   <= pos_d;
      done_q  <= done_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    per_d   = per_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    pos_d   = pos_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          dir_d = steps[STEP_WIDTH-1];
          rem_d = mag_w;
          per_d = per_w;
          cnt_d = per_w;
          if (mag_w == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (cnt_q == DIV_WIDTH'(1)) begin
          cnt_d   = per_q;
          phase_d = dir_q ? (phase_q - 2'd1) : (phase_q + 2'd1);
          pos_d   = dir_q ? (pos_q - POS_WIDTH'(1)) : (pos_q + POS_WIDTH'(1));
          rem_d   = rem_q - STEP_WIDTH'(1);
          if (rem_q == STEP_WIDTH'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Gray decode of the next phase, so a/b come straight from flops.
    a_d = phase_d[1] ^ phase_d[0];
    b_d = phase_d[1];
  end

  assign a    = a_q;
  assign b    = b_q;
  assign busy = (state_q == RUN);
  assign done = done_q;
  assign pos  = pos_q;

endmodule

`default_nettype wire

// File: tb/tb_encoder_emulator.sv
// ============================================================================
// tb_encoder_emulator : command table plus per-cycle scoreboard of a/b/busy/done/pos
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_encoder_emulator;

  logic               clk;
  logic               rst;
  logic               start;
  logic signed [7:0]  steps;
  logic [15:0]        period;
  logic               a;
  logic               b;
  logic               busy;
  logic               done;
  logic signed [15:0] pos;

  encoder_emulator #(
    .STEP_WIDTH(8),
    .DIV_WIDTH (16),
    .POS_WIDTH (16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .steps (steps),
    .period(period),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .pos   (pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [19:0] v;
  } rec_t;

  typedef struct {
    int         st;
    int         per;
    logic [1:0] ab;
    int         pos;
  } vec_t;

  rec_t        q[$];
  vec_t        tbl[7];
  logic [1:0]  gray[4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int          cyc = 0;
  int          cmp_n = 0;
  int          fail_n = 0;
  int          pos_m = 0;
  int          ph_m = 0;
  int          t0s = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected {a,b,busy,done,pos} records are popped on the falling edge of their cycle.
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc <= cyc) begin
      rec_t        r;
      logic [19:0] act;
      r   = q.pop_front();
      act = {a, b, busy, done, pos};
      cmp_n++;
      if (act !== r.v || r.cyc != cyc) begin
        fail_n++;
        $display("FAIL sb cyc=%0d (due %0d): got a,b,busy,done,pos=%05h expected %05h",
                 cyc, r.cyc, act, r.v);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    cmp_n++;
    if (act !== exp) begin
      fail_n++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive one command and push expected outputs for cycles t0..t0+jmax (-1: N*P+1).
  task automatic issue(input int st, input int per, input int jmax);
    int n, p, d, e, last, pm, ph;
    rec_t r;
    n = (st < 0) ? -st : st;
    p = (per == 0) ? 1 : per;
    d = (st < 0) ? -1 : 1;
    last = (jmax < 0) ? n * p + 1 : jmax;
    @(posedge clk); #1;
    start  = 1'b1;
    steps  = st[7:0];
    period = per[15:0];
    t0s    = cyc + 1;
    for (int j = 0; j <= last; j++) begin
      e = ((j / p) > n) ? n : (j / p);
      pm = pos_m + d * e;
      ph = (ph_m + d * e) & 3;
      r.cyc = t0s + j;
      r.v   = {gray[ph], (j < n * p), (j == n * p), pm[15:0]};
      q.push_back(r);
    end
    pm = pos_m + d * n;
    pos_m = int'($signed(pm[15:0]));
    ph_m  = (ph_m + d * n) & 3;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (q.size() > 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (q.size() > 0) begin
      cmp_n++;
      fail_n++;
      $display("FAIL drain: got %0d records outstanding expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    tbl[0] = '{ 4,   3, 2'b00,    4};
    tbl[1] = '{-2,   1, 2'b11,    2};
    tbl[2] = '{ 0,   5, 2'b11,    2};
    tbl[3] = '{ 1,   0, 2'b01,    3};
    tbl[4] = '{-128, 1, 2'b01, -125};
    tbl[5] = '{ 127, 1, 2'b11,    2};
    tbl[6] = '{-5,   2, 2'b10,   -3};

    rst = 1'b0; start = 1'b0; steps = '0; period = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", int'({a, b, busy, done}), 0);
    chk("reset_pos", int'(pos), 0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      issue(tbl[i].st, tbl[i].per, -1);
      drain(400);
      chk($sformatf("tbl%0d_ab", i), int'({a, b}), int'(tbl[i].ab));
      chk($sformatf("tbl%0d_pos", i), int'(pos), tbl[i].pos);
    end

    // Start during busy, at the completion edge (ignored) and one cycle later (accepted).
    issue(3, 4, 12);
    @(posedge clk); #1;
    start = 1'b1; steps = 8'sd5; period = 16'd1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < t0s + 11) begin
      @(posedge clk); #1;
    end
    start = 1'b1; steps = 8'sd2; period = 16'd1;
    issue(2, 1, -1);
    drain(100);
    chk("busy_seq_pos", int'(pos), 2);

    // Asynchronous reset in the middle of a run.
    issue(10, 2, 6);
    while (cyc < t0s + 7) begin
      @(posedge clk); #1;
    end
    drain(5);
    rst = 1'b0;
    #1;
    chk("midrst_outputs", int'({a, b, busy, done}), 0);
    chk("midrst_pos", int'(pos), 0);
    repeat (2) begin
      @(negedge clk);
      chk("midrst_no_done", int'(done), 0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    pos_m = 0; ph_m = 0;
    @(negedge clk);
    chk("post_rst_done", int'(done), 0);
    issue(3, 1, -1);
    drain(100);
    chk("post_rst_ab", int'({a, b}), int'(2'b01));

    // Climb to the positive limit, then wrap forward and back.
    while (pos_m != 32767) begin
      issue(((32767 - pos_m) > 127) ? 127 : (32767 - pos_m), 1, -1);
      drain(400);
    end
    chk("pos_max", int'(pos), 32767);
    issue(1, 1, -1);
    drain(100);
    chk("wrap_fwd", int'(pos), -32768);
    issue(-1, 1, -1);
    drain(100);
    chk("wrap_rev", int'(pos), 32767);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/encoder_emulator.md
# encoder_emulator

Quadrature encoder signal generator for the hdlcounter block: produces A/B channel waveforms equivalent to those of a real incremental encoder, moving a commanded signed number of steps at a programmable rate. It drives the encoder inputs of the hdlcounter counting path, through its input synchronisation stage, in bench and loopback self-test configurations. It also tracks the emitted position so a checker can compare it against the counter result.

## Interface
- STEP_WIDTH, 8: width of signed step request `steps`.
- DIV_WIDTH, 16: width of unsigned period `period` (clock cycles per quadrature edge).
- POS_WIDTH, 16: width of signed emitted position `pos`.

- clk  input  1  clock, all logic on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  command strobe; sampled on the rising edge of clk, accepted only when busy=0.
- steps  input  STEP_WIDTH  signed two's-complement step count; positive = forward, negative = reverse.
- period  input  DIV_WIDTH  clock cycles between consecutive edges; 0 treated as 1.
- a  output  1  encoder channel A, registered.
- b  output  1  encoder channel B, registered.
- busy  output  1  high while a command is executing.
- done  output  1  one-cycle pulse at command completion.
- pos  output  POS_WIDTH  signed running count of emitted edges, wraps modulo 2^POS_WIDTH.

## Operation
- One step = one quadrature edge (x4 resolution): exactly one of a/b toggles per step.
- 2-bit phase register, gray mapping phase→(a,b): 0→(0,0), 1→(1,0), 2→(1,1), 3→(0,1).
- Forward step: phase+1 mod 4 (A leads B). Reverse step: phase−1 mod 4.
- Phase persists across commands; only rst clears it.
- States: IDLE, RUN.
- IDLE with start=1:
  - latch direction = sign(steps) and remaining = |steps|, held as an unsigned STEP_WIDTH-bit value; −2^(STEP_WIDTH−1) gives a magnitude of 2^(STEP_WIDTH−1);
  - latch period P = max(period, 1);
  - load divider with P.
- If |steps| = 0: stay IDLE, pulse done, no edge, pos unchanged.
- Otherwise go to RUN, busy=1.
- RUN:
  - divider decrements each cycle;
  - on reaching the tick, emit one step (phase and pos update, pos ±1), decrement remaining and reload the divider with P;
  - after the final step, return to IDLE, busy=0, done=1.
- start while busy=1 is ignored; steps and period inputs are don't-care while busy.
- pos wraps: +1 from 2^(POS_WIDTH−1)−1 gives −2^(POS_WIDTH−1), and the reverse wrap also holds.
- a/b change only on the registered phase, so there are no combinational glitches on outputs.

## Timing
- Reset values: a=0, b=0, busy=0, done=0, pos=0, phase=0, state IDLE.
- Reset asserted mid-RUN: all outputs go to reset values immediately (asynchronously), the command is discarded, and there is no done pulse.
- Let t0 be the clk rising edge at which start is accepted.
- busy is high from t0.
- The k-th edge of a/b (k=1..N, N=|steps|) appears at edge t0 + k·P.
- pos updates at the same clk edge as its a/b edge.
- At t0 + N·P the final a/b edge, the pos update, busy→0 and done=1 all occur together; done drops at the next edge.
- start high at the completion edge is ignored, because busy was high when sampled. A new start is accepted from the following edge.
- Back-to-back commands therefore give a minimum inter-edge gap of P+1 across the boundary.
- N=0: done=1 from t0 for one cycle, busy stays 0.
- Minimum edge spacing is 1 clk (P=1). The consumer must tolerate one edge per cycle.

## Test plan
- Forward run: phase 0, start with steps=4, period=3 → (a,b) becomes 10,11,01,00 at t0+3, +6, +9, +12; pos 1,2,3,4; busy high t0..t0+11; done single pulse at t0+12.
- Reverse run: from phase 0, steps=−2, period=1 → (a,b)=01 at t0+1 and 11 at t0+2; pos −1, −2; done at t0+2.
- Degenerate commands:
  - steps=0 → done pulse at t0, busy never high, a/b/pos unchanged;
  - steps=1 with period=0 → behaves as period=1, single edge at t0+1.
- Start while busy: steps=3, period=4, second start with steps=5 at t0+2 → exactly 3 edges, one done at t0+12; start at t0+12 ignored, start at t0+13 accepted.
- Wrap and extreme:
  - POS_WIDTH=16, pos=32767, steps=1 → pos=−32768;
  - steps=−128 (STEP_WIDTH=8), period=1 → 128 reverse edges, pos decremented by 128, phase returns to its start value.
- Reset mid-run: steps=10, period=2, rst low at t0+7 → a=b=0, pos=0, busy=0 immediately, no done; new command after release runs normally from phase 0.
